// File: rtl/ready_level_gen.sv
// ready_level_gen
// Turns one-cycle converter strobes into a held `ready` level with a stable
// data word. A one-deep pending slot absorbs a sample that arrives while a
// word is being presented or during the low gap that follows it. Every word
// is followed by at least MIN_LOW low cycles plus one IDLE cycle, so each new
// word gives the consumer a distinct rising edge to detect.

module ready_level_gen #(
  parameter int DATA_W   = 12,
  parameter int MIN_HIGH = 4,
  parameter int MIN_LOW  = 2,
  parameter int TIMEOUT  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              ack,
  input  logic              clear_flags,
  output logic              ready,
  output logic [DATA_W-1:0] data_out,
  output logic              overrun,
  output logic              timeout,
  output logic [7:0]        drop_count
);

  // A timeout shorter than the minimum high time can never fire before the
  // word could legally end, so it is stretched to MIN_HIGH.
  localparam int TO_EFF  = (TIMEOUT > MIN_HIGH) ? TIMEOUT : MIN_HIGH;
  localparam bit TO_EN   = (TIMEOUT > 0);
  // The high counter holds (cycles spent in HIGH - 1); it only needs to reach
  // the last interesting value and then saturates there.
  localparam int CNT_MAX = TO_EN ? (TO_EFF - 1) : (MIN_HIGH - 1);
  localparam int HC_W    = $clog2(CNT_MAX + 2);
  localparam int GC_W    = $clog2(MIN_LOW + 1);

  localparam logic [HC_W-1:0] HC_MIN  = HC_W'(MIN_HIGH - 1);
  localparam logic [HC_W-1:0] HC_TO   = HC_W'(TO_EFF - 1);
  localparam logic [HC_W-1:0] HC_MAX  = HC_W'(CNT_MAX);
  localparam logic [HC_W-1:0] HC_ONE  = HC_W'(1);
  localparam logic [GC_W-1:0] GC_LAST = GC_W'(MIN_LOW - 1);
  localparam logic [GC_W-1:0] GC_ONE  = GC_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic              ready_next;
  logic [DATA_W-1:0] data_next;
  logic [HC_W-1:0]   high_cnt, high_cnt_next;
  logic [GC_W-1:0]   gap_cnt, gap_cnt_next;
  logic              ack_seen, ack_seen_next;

  logic              pend_valid, pend_valid_next;
  logic [DATA_W-1:0] pend_data, pend_data_next;

  logic              overrun_next;
  logic              timeout_next;
  logic [7:0]        drop_count_next;

  logic              ack_any;
  logic              min_met;
  logic              launch;
  logic              leave;
  logic              take_pend;
  logic              timeout_event;
  logic              drop_event;

  assign ack_any = ack_seen | ack;
  assign min_met = (high_cnt >= HC_MIN);

  // Next-state and word-presentation logic: launch from IDLE, hold in HIGH
  // until acked (or abandoned), then count out the low gap.
  always_comb begin
    state_next    = state;
    ready_next    = ready;
    data_next     = data_out;
    high_cnt_next = high_cnt;
    gap_cnt_next  = gap_cnt;
    ack_seen_next = ack_seen;
    launch        = 1'b0;
    leave         = 1'b0;
    take_pend     = 1'b0;
    timeout_event = 1'b0;

    case (state)
      IDLE: begin
        // The pending word is older than anything arriving now, so it goes first.
        if (pend_valid) begin
          launch    = 1'b1;
          take_pend = 1'b1;
          data_next = pend_data;
        end else if (sample_valid) begin
          launch    = 1'b1;
          data_next = sample_data;
        end
        if (launch) begin
          state_next    = HIGH;
          ready_next    = 1'b1;
          high_cnt_next = '0;
          ack_seen_next = 1'b0;
        end
      end

      HIGH: begin
        // An early ack is remembered so the word still ends at MIN_HIGH.
        ack_seen_next = ack_any;
        if (min_met && ack_any) begin
          leave = 1'b1;
        end else if (TO_EN && (high_cnt == HC_TO)) begin
          leave         = 1'b1;
          timeout_event = 1'b1;
        end else if (high_cnt != HC_MAX) begin
          high_cnt_next = high_cnt + HC_ONE;
        end
        if (leave) begin
          state_next   = GAP;
          ready_next   = 1'b0;
          gap_cnt_next = '0;
        end
      end

      GAP: begin
        if (gap_cnt == GC_LAST) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt + GC_ONE;
        end
      end

      default: begin
        state_next = IDLE;
        ready_next = 1'b0;
      end
    endcase
  end

  // State, presented word and the HIGH/GAP counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ready    <= 1'b0;
      data_out <= '0;
      high_cnt <= '0;
      gap_cnt  <= '0;
      ack_seen <= 1'b0;
    end else begin
      state    <= state_next;
      ready    <= ready_next;
      data_out <= data_next;
      high_cnt <= high_cnt_next;
      gap_cnt  <= gap_cnt_next;
      ack_seen <= ack_seen_next;
    end
  end

  // Pending slot: refilled in the same cycle it is drained by a launch,
  // otherwise filled only when empty; a sample hitting a full slot is dropped.
  always_comb begin
    pend_valid_next = pend_valid;
    pend_data_next  = pend_data;
    drop_event      = 1'b0;

    if (take_pend) begin
      pend_valid_next = sample_valid;
      if (sample_valid) begin
        pend_data_next = sample_data;
      end
    end else if (sample_valid && (state != IDLE)) begin
      if (!pend_valid) begin
        pend_valid_next = 1'b1;
        pend_data_next  = sample_data;
      end else begin
        drop_event = 1'b1;
      end
    end
  end

  // Pending slot registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
    end else begin
      pend_valid <= pend_valid_next;
      pend_data  <= pend_data_next;
    end
  end

  // Sticky flags and drop counter: a clear is applied first so that an event
  // in the same cycle survives it.
  always_comb begin
    overrun_next    = clear_flags ? 1'b0 : overrun;
    timeout_next    = clear_flags ? 1'b0 : timeout;
    drop_count_next = clear_flags ? 8'd0 : drop_count;

    if (drop_event) begin
      overrun_next = 1'b1;
      if (drop_count_next != 8'hFF) begin
        drop_count_next = drop_count_next + 8'd1;
      end
    end
    if (timeout_event) begin
      timeout_next = 1'b1;
    end
  end

  // Flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun    <= 1'b0;
      timeout    <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      overrun    <= overrun_next;
      timeout    <= timeout_next;
      drop_count <= drop_count_next;
    end
  end

endmodule

// File: tb/tb_ready_level_gen.sv
// Bench for ready_level_gen: two instances (no timeout, TIMEOUT=8) share one
// stimulus stream and are checked every cycle against a timestamp-based model.
`timescale 1ns/1ps

module tb_ready_level_gen;

  localparam int MIN_HIGH = 4;
  localparam int MIN_LOW  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [11:0] sample_data;
  logic        ack;
  logic        clear_flags;

  logic        rdy0, rdy1;
  logic [11:0] dout0, dout1;
  logic        ovr0, ovr1;
  logic        tmo0, tmo1;
  logic [7:0]  dcnt0, dcnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ready_level_gen #(.DATA_W(12), .MIN_HIGH(MIN_HIGH), .MIN_LOW(MIN_LOW), .TIMEOUT(0)) dut0 (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_data(sample_data),
    .ack(ack), .clear_flags(clear_flags), .ready(rdy0), .data_out(dout0),
    .overrun(ovr0), .timeout(tmo0), .drop_count(dcnt0)
  );

  ready_level_gen #(.DATA_W(12), .MIN_HIGH(MIN_HIGH), .MIN_LOW(MIN_LOW), .TIMEOUT(8)) dut1 (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_data(sample_data),
    .ack(ack), .clear_flags(clear_flags), .ready(rdy1), .data_out(dout1),
    .overrun(ovr1), .timeout(tmo1), .drop_count(dcnt1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (event times, not states) ----------------
  bit          m_inword[2];
  int          m_rise[2];
  logic [11:0] m_data[2];
  bit          m_acked[2];
  int          m_free[2];
  bit          m_pv[2];
  logic [11:0] m_pd[2];
  bit          m_ovr[2];
  bit          m_to[2];
  int          m_cnt[2];
  int          m_last_len[2];

  function automatic int to_eff(input int i);
    return (i == 0) ? 0 : ((8 > MIN_HIGH) ? 8 : MIN_HIGH);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_inword[i] = 0; m_rise[i] = 0; m_data[i] = 0; m_acked[i] = 0; m_free[i] = 0;
      m_pv[i] = 0; m_pd[i] = 0; m_ovr[i] = 0; m_to[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input int t, input logic sv, input logic [11:0] sd,
                            input logic a, input logic clr);
    bit drop;
    bit tev;
    bit busy;
    int k;
    drop = 0;
    tev  = 0;
    busy = 0;
    if (m_inword[i]) begin
      busy = 1;
      k = t - m_rise[i];
      if (a) m_acked[i] = 1;
      if (k >= MIN_HIGH && m_acked[i]) begin
        m_inword[i] = 0;
      end else if (to_eff(i) > 0 && k >= to_eff(i)) begin
        m_inword[i] = 0;
        tev = 1;
      end
      if (!m_inword[i]) begin
        m_free[i]     = t + MIN_LOW + 1;
        m_last_len[i] = k;
      end
    end else if (t < m_free[i]) begin
      busy = 1;
    end else if (m_pv[i]) begin
      m_inword[i] = 1; m_rise[i] = t; m_data[i] = m_pd[i]; m_acked[i] = 0;
      m_pv[i] = sv;
      if (sv) m_pd[i] = sd;
    end else if (sv) begin
      m_inword[i] = 1; m_rise[i] = t; m_data[i] = sd; m_acked[i] = 0;
    end
    if (busy && sv) begin
      if (m_pv[i]) drop = 1;
      else begin
        m_pv[i] = 1;
        m_pd[i] = sd;
      end
    end
    if (clr) begin
      m_ovr[i] = 0; m_to[i] = 0; m_cnt[i] = 0;
    end
    if (drop) begin
      m_ovr[i] = 1;
      m_cnt[i] = (m_cnt[i] >= 255) ? 255 : m_cnt[i] + 1;
    end
    if (tev) m_to[i] = 1;
  endtask

  task automatic cmp(input int i, input logic r, input logic [11:0] d, input logic o,
                     input logic tm, input logic [7:0] c);
    chk($sformatf("i%0d ready", i), r, m_inword[i]);
    chk($sformatf("i%0d data_out", i), d, m_data[i]);
    chk($sformatf("i%0d overrun", i), o, m_ovr[i]);
    chk($sformatf("i%0d timeout", i), tm, m_to[i]);
    chk($sformatf("i%0d drop_count", i), c, m_cnt[i]);
  endtask

  // Compare process: advance the model on each rising edge, check just after.
  initial begin
    int          cyc;
    logic        cs_v, cs_a, cs_c, cs_r;
    logic [11:0] cs_d;
    cyc = 0;
    model_reset();
    forever begin
      @(posedge clk);
      cs_v = sample_valid; cs_d = sample_data; cs_a = ack; cs_c = clear_flags; cs_r = reset;
      #1;
      if (!cs_r) begin
        model_reset();
      end else begin
        model_step(0, cyc, cs_v, cs_d, cs_a, cs_c);
        model_step(1, cyc, cs_v, cs_d, cs_a, cs_c);
      end
      cyc++;
      cmp(0, rdy0, dout0, ovr0, tmo0, dcnt0);
      cmp(1, rdy1, dout1, ovr1, tmo1, dcnt1);
    end
  end

  // ---------------- stimulus-side word log ----------------
  int ns;
  bit prev[2];
  int start[2];
  int r_n[2];
  int l_n[2];
  int r_t[2][16];
  int r_d[2][16];
  int r_len[2][16];
  bit verbose;

  task automatic clear_log();
    for (int i = 0; i < 2; i++) begin
      r_n[i] = 0;
      l_n[i] = 0;
      for (int j = 0; j < 16; j++) begin
        r_t[i][j] = -1; r_d[i][j] = -1; r_len[i][j] = -1;
      end
    end
  endtask

  task automatic drive(input logic sv, input logic [11:0] sd, input logic a, input logic c);
    logic        cur;
    logic [11:0] d;
    @(negedge clk);
    ns++;
    for (int i = 0; i < 2; i++) begin
      cur = (i == 0) ? rdy0 : rdy1;
      d   = (i == 0) ? dout0 : dout1;
      if (cur && !prev[i]) begin
        if (r_n[i] < 16) begin
          r_t[i][r_n[i]] = ns;
          r_d[i][r_n[i]] = int'(d);
        end
        r_n[i]++;
        start[i] = ns;
        if (verbose) $display("word inst%0d t=%0d data=%03h", i, ns, d);
      end
      if (!cur && prev[i]) begin
        if (l_n[i] < 16) r_len[i][l_n[i]] = ns - start[i];
        l_n[i]++;
      end
      prev[i] = cur;
    end
    sample_valid = sv;
    sample_data  = sd;
    ack          = a;
    clear_flags  = c;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time limit required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sample_valid = 0; sample_data = 0; ack = 0; clear_flags = 0; reset = 0;
    ns = 0; prev[0] = 0; prev[1] = 0; start[0] = 0; start[1] = 0; verbose = 1;
    clear_log();
    repeat (3) @(negedge clk);
    chk("reset ready", rdy0, 0);
    chk("reset data_out", dout0, 0);
    chk("reset drop_count", dcnt0, 0);
    reset = 1;

    // Reset in the middle of a word clears everything at once.
    drive(1, 12'h777, 1, 0);
    drive(1, 12'h778, 1, 0);
    drive(1, 12'h779, 1, 0);
    drive(0, 0, 0, 0);
    chk("pre-reset ready", rdy0, 1);
    chk("pre-reset overrun", ovr0, 1);
    chk("pre-reset drop_count", dcnt0, 1);
    #2 reset = 0;
    #1;
    chk("async reset ready", rdy0, 0);
    chk("async reset ready i1", rdy1, 0);
    chk("async reset data_out", dout0, 0);
    chk("async reset overrun", ovr0, 0);
    chk("async reset drop_count", dcnt0, 0);
    @(negedge clk);
    reset = 1;
    prev[0] = 0; prev[1] = 0;
    clear_log();

    // Single sample, ack tied high.
    drive(1, 12'hABC, 1, 0);
    repeat (10) drive(0, 0, 1, 0);
    chk("single words", r_n[0], 1);
    chk("single data", r_d[0][0], 32'hABC);
    chk("single high len", r_len[0][0], 4);
    chk("model single len", m_last_len[0], 4);

    // Early ack pulse.
    clear_log();
    drive(1, 12'h5A5, 0, 0);
    drive(0, 0, 1, 0);
    repeat (10) drive(0, 0, 0, 0);
    chk("early ack data", r_d[0][0], 32'h5A5);
    chk("early ack high len", r_len[0][0], 4);

    // Late ack pulse, ten cycles after the rise.
    clear_log();
    drive(1, 12'h3C3, 0, 0);
    repeat (9) drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);
    repeat (6) drive(0, 0, 0, 0);
    chk("late ack high len", r_len[0][0], 10);
    chk("late ack timeout i1", tmo1, 1);
    chk("late ack timeout i0", tmo0, 0);
    drive(0, 0, 0, 1);

    // Pending word launched after the gap.
    clear_log();
    drive(1, 12'h111, 1, 0);
    repeat (2) drive(0, 0, 1, 0);
    drive(1, 12'h222, 1, 0);
    repeat (16) drive(0, 0, 1, 0);
    chk("pending words", r_n[0], 2);
    chk("pending data0", r_d[0][0], 32'h111);
    chk("pending data1", r_d[0][1], 32'h222);
    chk("pending rise spacing", r_t[0][1] - r_t[0][0], 7);
    chk("pending high len", r_len[0][0], 4);

    // Overrun: four back-to-back samples.
    drive(0, 0, 1, 1);
    clear_log();
    drive(1, 12'h001, 1, 0);
    drive(1, 12'h002, 1, 0);
    drive(1, 12'h003, 1, 0);
    drive(1, 12'h004, 1, 0);
    repeat (16) drive(0, 0, 1, 0);
    chk("overrun words", r_n[0], 2);
    chk("overrun data0", r_d[0][0], 32'h001);
    chk("overrun data1", r_d[0][1], 32'h002);
    chk("overrun flag", ovr0, 1);
    chk("overrun count", dcnt0, 2);
    chk("model overrun count", m_cnt[0], 2);
    drive(0, 0, 1, 1);
    drive(0, 0, 1, 0);
    chk("cleared overrun", ovr0, 0);
    chk("cleared count", dcnt0, 0);

    // Timeout (second instance), then the pending word is presented.
    repeat (5) drive(0, 0, 1, 0);
    clear_log();
    drive(1, 12'h0AA, 0, 0);
    drive(1, 12'h0BB, 0, 0);
    repeat (25) drive(0, 0, 0, 0);
    chk("timeout high len", r_len[1][0], 8);
    chk("timeout data0", r_d[1][0], 32'h0AA);
    chk("timeout data1", r_d[1][1], 32'h0BB);
    chk("timeout rise spacing", r_t[1][1] - r_t[1][0], 11);
    chk("timeout second len", r_len[1][1], 8);
    chk("timeout flag", tmo1, 1);
    chk("no timeout i0", tmo0, 0);
    chk("i0 still holding", rdy0, 1);
    chk("model timeout flag", m_to[1], 1);
    repeat (30) drive(0, 0, 1, 0);
    drive(0, 0, 1, 1);
    drive(0, 0, 1, 0);
    chk("cleared timeout", tmo1, 0);

    // Clear coinciding with a drop; a sample in the launching IDLE cycle.
    repeat (5) drive(0, 0, 1, 0);
    clear_log();
    drive(1, 12'h010, 1, 0);
    drive(1, 12'h020, 1, 0);
    drive(1, 12'h030, 1, 0);
    drive(1, 12'h040, 1, 1);
    drive(0, 0, 1, 0);
    chk("clear+drop overrun", ovr0, 1);
    chk("clear+drop count", dcnt0, 1);
    repeat (2) drive(0, 0, 1, 0);
    drive(1, 12'h050, 1, 0);
    repeat (20) drive(0, 0, 1, 0);
    chk("relaunch words", r_n[0], 3);
    chk("relaunch data1", r_d[0][1], 32'h020);
    chk("relaunch data2", r_d[0][2], 32'h050);
    chk("relaunch spacing", r_t[0][2] - r_t[0][1], 7);

    // Drop counter saturation.
    drive(0, 0, 1, 1);
    for (int n = 0; n < 300; n++) drive(1, 12'($urandom), 0, 0);
    drive(0, 0, 0, 0);
    chk("saturated count", dcnt0, 255);
    chk("model saturated count", m_cnt[0], 255);
    drive(0, 0, 1, 1);
    drive(0, 0, 1, 0);
    chk("count after clear", dcnt0, 0);
    repeat (20) drive(0, 0, 1, 0);

    // Randomised traffic with occasional asynchronous resets.
    verbose = 0;
    for (int n = 0; n < 2500; n++) begin
      logic a;
      int   mode;
      if (n % 600 == 599) begin
        @(negedge clk);
        #2 reset = 0;
        @(negedge clk);
        reset = 1;
      end
      mode = (n / 200) % 3;
      if (mode == 0)      a = ($urandom_range(0, 1) == 0);
      else if (mode == 1) a = 1'b1;
      else                a = ($urandom_range(0, 19) == 0);
      drive(($urandom_range(0, 2) == 0), 12'($urandom), a, ($urandom_range(0, 39) == 0));
    end
    drive(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ready_level_gen.md
# ready_level_gen

Producer side of the ready handshake: turns one-cycle sample strobes from the discrete-ADC converter into a held `ready` level with a stable data word. Downstream logic edge-detects `ready` and returns `ack`. A one-deep pending buffer absorbs a sample that arrives while a word is still being presented. A guaranteed low gap between words makes every new word produce a distinct rising edge.

## Interface
- `DATA_W`, default 12: width of sample word.
- `MIN_HIGH`, default 4: minimum cycles `ready` stays high (≥1).
- `MIN_LOW`, default 2: cycles `ready` stays low between words (≥1).
- `TIMEOUT`, default 0: cycles in HIGH without `ack` before the word is abandoned; 0 disables.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `sample_valid`  in  1  one-cycle strobe: `sample_data` is valid this cycle.
- `sample_data`  in  DATA_W  converter result.
- `ack`  in  1  consumer has taken the word; level or pulse, sampled each cycle.
- `clear_flags`  in  1  synchronous clear of `overrun`, `timeout`, `drop_count`.
- `ready`  out  1  registered level; high while `data_out` is presented.
- `data_out`  out  DATA_W  registered word; stable for the whole time `ready` is high.
- `overrun`  out  1  sticky: a sample was dropped.
- `timeout`  out  1  sticky: a word was abandoned by timeout.
- `drop_count`  out  8  saturating count of dropped samples, saturates at 255.

## Operation
- **States:** IDLE, HIGH, GAP. A separate `pend_valid`/`pend_data` register holds the pending sample.
- **Reset values:** state IDLE, `ready` 0, `data_out` 0, `pend_valid` 0, `overrun` 0, `timeout` 0, `drop_count` 0, all counters 0.
- **IDLE:**
  - If `pend_valid`: load `pend_data` into `data_out` and go to HIGH. A `sample_valid` in the same cycle is written into pending, since the slot frees that cycle.
  - Else if `sample_valid`: load `sample_data` directly and go to HIGH.
- **HIGH:**
  - `ready` is 1. The high counter counts up from entry, and `ack_seen` latches any `ack`, including an early one.
  - Exit to GAP when the counter ≥ MIN_HIGH and (`ack_seen` or `ack`).
  - If TIMEOUT > 0 and no ack arrives within TIMEOUT cycles of entry: exit to GAP and set `timeout`. TIMEOUT < MIN_HIGH is treated as MIN_HIGH.
- **GAP:**
  - `ready` is 0 for exactly MIN_LOW cycles, then the block goes to IDLE.
  - IDLE immediately re-launches if `pend_valid` is set.
- **Pending buffer:** `sample_valid` in HIGH or GAP writes pending if it is empty.
  - If pending is full, the new sample is dropped. The pending word is kept (oldest wins), `overrun` is set, and `drop_count` increments.
- **Flags:** `clear_flags` zeros the flags. A drop or timeout in the same cycle as `clear_flags` wins, leaving flag = 1 and count = 1.
- `data_out` changes only on the transition into HIGH.
- **Reset mid-word:** `ready` drops immediately and asynchronously. Pending and in-flight words are discarded without counting as drops.

## Timing
- `sample_valid` at edge N in IDLE gives `ready` = 1 and `data_out` valid after edge N, i.e. visible in cycle N+1. Latency is 1.
- **Minimum `ready` high time:** MIN_HIGH cycles. `ack` held high from the start gives exactly MIN_HIGH cycles.
- **Late ack:** `ack` first seen at edge M, with M ≥ entry + MIN_HIGH, drops `ready` after edge M.
- **Word-to-word spacing from pending:** `ready` falls, stays low MIN_LOW cycles, then has 1 IDLE cycle, then rises. The minimum period is MIN_HIGH + MIN_LOW + 1.
- **Throughput:** at most one word per MIN_HIGH + MIN_LOW + 1 cycles. Faster sample rates overrun.

## Test plan
1. **Reset / single sample:** assert `reset` = 0 mid-HIGH → all outputs 0 at once. After release, `sample_valid` with 0xABC, `ack` tied 1 → `ready` high exactly 4 cycles, `data_out` = 0xABC, then low 2 cycles.
2. **Early and late ack:** pulse `ack` 1 cycle after `ready` rises → `ready` still high 4 cycles. Pulse `ack` 10 cycles after the rise → `ready` falls the cycle after that `ack`.
3. **Pending:** samples 0x111 then 0x222 three cycles apart, `ack` = 1 → two `ready` pulses with data 0x111 then 0x222. Rising edges are 7 cycles apart; the low gap is 2 cycles plus the IDLE cycle.
4. **Overrun:** four samples 0x001–0x004 on consecutive cycles, `ack` = 1 → words 0x001 and 0x002 delivered, `overrun` = 1, `drop_count` = 2. `clear_flags` then zeros both.
5. **Timeout:** TIMEOUT = 8, no `ack` → `ready` high 8 cycles, then falls, `timeout` = 1. A pending word is then presented normally.
6. **Simultaneous events:** `clear_flags` in the same cycle as a drop → `overrun` = 1, `drop_count` = 1. `sample_valid` in the IDLE cycle that launches pending → the new sample is presented as the next word.
